bcrypt_b64_out: RTL and testbench
=================================

Name: bcrypt_b64_out

Overview:
- Downstream of the hash/reset output stage. Accepts the final 326-bit packed result {cost[5:0], salt[127:0], ctext[191:0]} once per hash.
- Serialises it as the standard 60-character bcrypt string "$2<v>$NN$<22 salt chars><31 hash chars>", one ASCII byte per handshake.
- Feeds the UART transmitter, replacing the simulation-only base64 printing with synthesizable logic.

Parameters:
- VERSION_CHAR, 8'h61 ('a'): third character of the prefix.
- COST_DEC, 1: 1 = cost printed as two decimal digits; 0 = two lowercase hex digits of {2'b0,cost}.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- hash  input  326  packed result; [325:320] cost, [319:192] salt, [191:0] ctext.
- hash_valid  input  1  hash is presented.
- hash_ready  output  1  block can capture a new hash.
- char_out  output  8  current ASCII character.
- char_valid  output  1  char_out is valid.
- char_ready  input  1  consumer accepts char_out.
- char_last  output  1  char_out is character 59, the final one.
- done  output  1  one-cycle pulse after the final character is accepted.

Behaviour:
- Reset is synchronous and active-high; all outputs are registered except hash_ready.
- Reset values: state=IDLE, idx=0, char_out=8'h00, char_valid=0, char_last=0, done=0, capture register=0.
- hash_ready = (state==IDLE) & ~rst.
- States:
  - IDLE: on hash_valid & hash_ready, latch hash into a 326-bit register, idx←0, go to EMIT. char_valid rises the next cycle with character 0 (1-cycle latency).
  - EMIT: char_valid=1. char_out and char_last hold stable while char_ready=0.
    - On char_valid & char_ready with idx<59: idx←idx+1 and load the next character the same edge. No bubbles, so 1 character per cycle under continuous ready.
    - On char_valid & char_ready with idx==59: char_valid←0, char_last←0, done←1 for one cycle, go to IDLE. hash_ready is 1 in the cycle after the final transfer.
- Character map by idx:
  - 0 '$'; 1 '2'; 2 VERSION_CHAR; 3 '$'.
  - 4 and 5: cost digits. Decimal: tens=cost/10 and ones=cost%10, covering 0..63, with a leading '0' below 10. Hex: hi nibble, lo nibble.
  - 6 '$'.
  - 7..27: salt symbol k=idx-7 = hash[319-6k -: 6].
  - 28: {hash[193:192],4'b0}.
  - 29..58: ctext symbol k=idx-29 = hash[191-6k -: 6].
  - 59: {hash[11:8],2'b0}. hash[7:0] is ignored.
- Alphabet (6-bit value v → ASCII):
  - 0 '.', 1 '/'.
  - 2..27 'A'+(v-2).
  - 28..53 'a'+(v-28).
  - 54..63 '0'+(v-54).
- Boundary conditions:
  - hash_valid while not IDLE is ignored, with no capture and no side effects.
  - Changes to the hash input after capture have no effect on the current string.
  - char_ready high while char_valid=0 has no effect.
  - idx never exceeds 59 and does not wrap.
  - rst mid-stream aborts immediately: next edge returns to reset values, nothing further is emitted, the partial string is discarded, and hash_ready=1 once rst deasserts.
  - rst and hash_valid in the same cycle: no capture.
  - Back-to-back hashes: a new capture is possible the cycle after done, with no lost or duplicated characters.

Test Plan:
1. hash=0 except cost=6, char_ready=1 → 60 consecutive cycles of "$2a$06$" followed by 53 '.'. char_last only on the 60th. done pulses once. hash_ready=0 throughout, then 1.
2. cost=31, hash[319:8] all ones, COST_DEC=1 → "$2a$31$" + 21×'9' + 'u' + 30×'9' + '6'.
3. cost=6, COST_DEC=0 → characters 4–5 are "06". cost=63 with COST_DEC=1 → "63"; with COST_DEC=0 → "3f".
4. Drop char_ready for 5 cycles while idx=3 → char_out holds 8'h24 ('$') with char_valid=1. Resume → idx 4 follows with no skip or duplicate. Total accepted = 60.
5. Assert rst for 1 cycle at idx=20 → char_valid=0 on the next edge and no done pulse. New hash accepted after release produces a full, correct 60-character string.
6. Pulse hash_valid with different data at idx=10 → ignored; string is unchanged. Hold hash_valid continuously → two complete strings, the second starting 1 cycle after the first done.

Source files
------------

// File: rtl/bcrypt_b64_out_if.sv
// Hash capture and character stream handshake bundle for bcrypt_b64_out.
interface bcrypt_b64_out_if;
  logic [325:0] hash;
  logic         hash_valid;
  logic         hash_ready;
  logic [7:0]   char_out;
  logic         char_valid;
  logic         char_ready;
  logic         char_last;
  logic         done;

  modport master (
    output hash, hash_valid, char_ready,
    input  hash_ready, char_out, char_valid, char_last, done
  );

  modport slave (
    input  hash, hash_valid, char_ready,
    output hash_ready, char_out, char_valid, char_last, done
  );
endinterface

// File: rtl/bcrypt_b64_out.sv
// Serialises a captured {cost, salt, ctext} result into the 60-character
// bcrypt string "$2<v>$NN$<salt><hash>", one ASCII byte per handshake.
module bcrypt_b64_out #(
  parameter logic [7:0] VERSION_CHAR = 8'h61,
  parameter bit         COST_DEC     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  bcrypt_b64_out_if.slave  bus
);

  localparam int unsigned HASH_W = 326;
  localparam int unsigned IDX_W  = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(59);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HASH_W-1:0] hash_q, hash_d;
  logic [7:0]        char_q, char_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [7:0]        next_char;

  // bcrypt base64 alphabet: ./A-Za-z0-9
  function automatic logic [7:0] b64(input logic [5:0] v);
    logic [7:0] c;
    if (v == 6'd0)       c = 8'h2e;
    else if (v == 6'd1)  c = 8'h2f;
    else if (v < 6'd28)  c = 8'(v) + 8'd63;
    else if (v < 6'd54)  c = 8'(v) + 8'd69;
    else                 c = 8'(v) - 8'd6;
    return c;
  endfunction

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h57 + 8'(n));
  endfunction

  function automatic logic [7:0] char_at(input logic [IDX_W-1:0] idx,
                                         input logic [HASH_W-1:0] h);
    logic [5:0] cost;
    logic [5:0] k;
    logic [8:0] base;
    logic [7:0] c;
    cost = h[325:320];
    k    = '0;
    base = '0;
    if (idx == 6'd0 || idx == 6'd3 || idx == 6'd6) c = 8'h24;
    else if (idx == 6'd1) c = 8'h32;
    else if (idx == 6'd2) c = VERSION_CHAR;
    else if (idx == 6'd4)
      c = COST_DEC ? (8'h30 + 8'(cost / 6'd10)) : hex_ch({2'b00, cost[5:4]});
    else if (idx == 6'd5)
      c = COST_DEC ? (8'h30 + 8'(cost % 6'd10)) : hex_ch(cost[3:0]);
    else if (idx <= 6'd27) begin
      k    = idx - 6'd7;
      base = 9'd319 - 9'(k) * 9'd6;
      c    = b64(h[base -: 6]);
    end
    else if (idx == 6'd28) c = b64({h[193:192], 4'b0000});
    else if (idx <= 6'd58) begin
      k    = idx - 6'd29;
      base = 9'd191 - 9'(k) * 9'd6;
      c    = b64(h[base -: 6]);
    end
    else c = b64({h[11:8], 2'b00});
    return c;
  endfunction

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hash_d    = hash_q;
    char_d    = char_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    next_char = char_at(idx_q + IDX_W'(1), hash_q);
    case (state_q)
      S_IDLE: begin
        if (bus.hash_valid) begin
          hash_d  = bus.hash;
          idx_d   = '0;
          char_d  = 8'h24;
          valid_d = 1'b1;
          last_d  = 1'b0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (valid_q && bus.char_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            char_d = next_char;
            last_d = (idx_q == LAST_IDX - IDX_W'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hash_q  <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hash_q  <= hash_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.hash_ready = (state_q == S_IDLE) & ~rst;
  assign bus.char_out   = char_q;
  assign bus.char_valid = valid_q;
  assign bus.char_last  = last_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_bcrypt_b64_out.sv
// Directed self-checking bench for bcrypt_b64_out (decimal and hex cost builds).
module tb_bcrypt_b64_out;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcrypt_b64_out_if ifd ();
  bcrypt_b64_out_if ifh ();

  bcrypt_b64_out #(.VERSION_CHAR(8'h61), .COST_DEC(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(ifd.slave)
  );

  bcrypt_b64_out #(.VERSION_CHAR(8'h61), .COST_DEC(1'b0)) dut_hex (
    .clk(clk), .rst(rst), .bus(ifh.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [325:0] h1, h2, h63;
  string exp1, exp2, exp63;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string rep(input string c, input int n);
    string s;
    s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  task automatic send_hash(input string name, input logic [325:0] h, input bit keep);
    ifd.hash = h;
    ifd.hash_valid = 1'b1;
    #0;
    n_cmp++;
    if (ifd.hash_ready !== 1'b1) begin
      n_err++; $display("FAIL %s hash_ready before capture: got %b want 1", name, ifd.hash_ready);
    end
    step();
    if (!keep) begin
      ifd.hash_valid = 1'b0;
      ifd.hash = ~h;
    end
  endtask

  // Accepts characters, checking each against exp; optional stall and ignored-capture pulse.
  task automatic recv(input string name, input string exp, input int stall_at,
                      input int pulse_at, input logic [325:0] pulse_h,
                      input bit keep_valid, input int stop_n);
    int n, cyc, want_cyc;
    bit stalled;
    n = 0; cyc = 0; stalled = 0;
    ifd.char_ready = 1'b1;
    while (n < stop_n && cyc < 400) begin
      if (n == stall_at && !stalled) begin
        stalled = 1;
        ifd.char_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step(); cyc++;
          n_cmp++;
          if (ifd.char_valid !== 1'b1 || ifd.char_out !== 8'(exp[n])) begin
            n_err++;
            $display("FAIL %s stall hold %0d: got valid=%b char=%h want valid=1 char=%h",
                     name, s, ifd.char_valid, ifd.char_out, 8'(exp[n]));
          end
        end
        ifd.char_ready = 1'b1;
      end
      if (n == pulse_at) begin
        ifd.hash_valid = 1'b1;
        ifd.hash = pulse_h;
      end else if (!keep_valid) begin
        ifd.hash_valid = 1'b0;
      end
      n_cmp++;
      if (ifd.char_valid !== 1'b1) begin
        n_err++; $display("FAIL %s char_valid at cycle %0d: got %b want 1", name, cyc, ifd.char_valid);
      end else begin
        n_cmp++;
        if (ifd.char_out !== 8'(exp[n])) begin
          n_err++; $display("FAIL %s char %0d: got %h want %h", name, n, ifd.char_out, 8'(exp[n]));
        end
        n_cmp++;
        if (ifd.char_last !== (n == 59)) begin
          n_err++; $display("FAIL %s char_last at %0d: got %b want %b", name, n, ifd.char_last, (n == 59));
        end
        n_cmp++;
        if (ifd.hash_ready !== 1'b0 || ifd.done !== 1'b0) begin
          n_err++; $display("FAIL %s busy flags at %0d: got ready=%b done=%b want 0 0",
                            name, n, ifd.hash_ready, ifd.done);
        end
        n++;
      end
      step(); cyc++;
    end
    if (!keep_valid) ifd.hash_valid = 1'b0;
    if (stop_n == 60) begin
      want_cyc = (stall_at >= 0) ? 65 : 60;
      n_cmp++;
      if (n != 60 || cyc != want_cyc) begin
        n_err++; $display("FAIL %s length: got %0d chars in %0d cycles want 60 in %0d", name, n, cyc, want_cyc);
      end
      n_cmp++;
      if (ifd.done !== 1'b1 || ifd.char_valid !== 1'b0 || ifd.char_last !== 1'b0 || ifd.hash_ready !== 1'b1) begin
        n_err++;
        $display("FAIL %s end: got done=%b valid=%b last=%b ready=%b want 1 0 0 1",
                 name, ifd.done, ifd.char_valid, ifd.char_last, ifd.hash_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifd.hash = h1; ifd.hash_valid = 1'b1; ifd.char_ready = 1'b1;
    ifh.hash = '0; ifh.hash_valid = 1'b0; ifh.char_ready = 1'b1;
    step(); step();
    n_cmp++;
    if (ifd.char_valid !== 1'b0 || ifd.char_out !== 8'h00 || ifd.char_last !== 1'b0 ||
        ifd.done !== 1'b0 || ifd.hash_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got valid=%b char=%h last=%b done=%b ready=%b want 0 00 0 0 0",
               ifd.char_valid, ifd.char_out, ifd.char_last, ifd.done, ifd.hash_ready);
    end
    rst = 1'b0; ifd.hash_valid = 1'b0;
    #1;
    n_cmp++;
    if (ifd.hash_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release ready: got %b want 1", ifd.hash_ready);
    end
    step(); step();
    n_cmp++;
    if (ifd.char_valid !== 1'b0 || ifd.hash_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_no_capture: got valid=%b ready=%b want 0 1", ifd.char_valid, ifd.hash_ready);
    end
  endtask

  task automatic test_basic();
    send_hash("basic", h1, 1'b0);
    recv("basic", exp1, -1, -1, '0, 1'b0, 60);
    step(); step();
    n_cmp++;
    if (ifd.done !== 1'b0 || ifd.char_valid !== 1'b0 || ifd.hash_ready !== 1'b1) begin
      n_err++; $display("FAIL basic idle: got done=%b valid=%b ready=%b want 0 0 1",
                        ifd.done, ifd.char_valid, ifd.hash_ready);
    end
  endtask

  task automatic test_all_ones();
    send_hash("all_ones", h2, 1'b0);
    recv("all_ones", exp2, -1, -1, '0, 1'b0, 60);
    step();
  endtask

  task automatic test_cost63_dec();
    send_hash("cost63_dec", h63, 1'b0);
    recv("cost63_dec", exp63, -1, -1, '0, 1'b0, 60);
    step();
  endtask

  task automatic test_hex_cost(input logic [325:0] h, input logic [7:0] c4, input logic [7:0] c5);
    logic [7:0] got4, got5;
    int n;
    n = 0; got4 = '0; got5 = '0;
    ifh.hash = h; ifh.hash_valid = 1'b1; ifh.char_ready = 1'b1;
    step();
    ifh.hash_valid = 1'b0;
    for (int cyc = 0; cyc < 100 && n < 60; cyc++) begin
      if (ifh.char_valid === 1'b1) begin
        if (n == 4) got4 = ifh.char_out;
        if (n == 5) got5 = ifh.char_out;
        n++;
      end
      step();
    end
    n_cmp++;
    if (n != 60 || ifh.done !== 1'b1) begin
      n_err++; $display("FAIL hex length: got %0d chars done=%b want 60 1", n, ifh.done);
    end
    n_cmp++;
    if (got4 !== c4 || got5 !== c5) begin
      n_err++; $display("FAIL hex cost digits: got %h %h want %h %h", got4, got5, c4, c5);
    end
    step();
  endtask

  task automatic test_stall();
    send_hash("stall", h1, 1'b0);
    recv("stall", exp1, 3, -1, '0, 1'b0, 60);
    step();
  endtask

  task automatic test_reset_mid();
    send_hash("rst_mid", h1, 1'b0);
    recv("rst_mid", exp1, -1, -1, '0, 1'b0, 20);
    rst = 1'b1;
    step();
    n_cmp++;
    if (ifd.char_valid !== 1'b0 || ifd.done !== 1'b0 || ifd.hash_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_mid abort: got valid=%b done=%b ready=%b want 0 0 0",
                        ifd.char_valid, ifd.done, ifd.hash_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ifd.hash_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid ready: got %b want 1", ifd.hash_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (ifd.char_valid !== 1'b0 || ifd.done !== 1'b0) begin
        n_err++; $display("FAIL rst_mid quiet %0d: got valid=%b done=%b want 0 0", i, ifd.char_valid, ifd.done);
      end
    end
    send_hash("rst_mid_new", h2, 1'b0);
    recv("rst_mid_new", exp2, -1, -1, '0, 1'b0, 60);
    step();
  endtask

  task automatic test_ignore_capture();
    send_hash("ignore", h1, 1'b0);
    recv("ignore", exp1, -1, 10, h2, 1'b0, 60);
    step();
  endtask

  task automatic test_back_to_back();
    send_hash("b2b_first", h2, 1'b1);
    recv("b2b_first", exp2, -1, -1, '0, 1'b1, 60);
    step();
    recv("b2b_second", exp2, -1, -1, '0, 1'b1, 60);
    ifd.hash_valid = 1'b0;
    step(); step();
    n_cmp++;
    if (ifd.char_valid !== 1'b0 || ifd.hash_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b idle: got valid=%b ready=%b want 0 1", ifd.char_valid, ifd.hash_ready);
    end
  endtask

  initial begin
    h1  = {6'd6, 320'd0};
    h2  = {6'd31, {312{1'b1}}, 8'h00};
    h63 = {6'd63, 320'd0};
    exp1  = {"$2a$06$", rep(".", 53)};
    exp2  = {"$2a$31$", rep("9", 21), "u", rep("9", 30), "6"};
    exp63 = {"$2a$63$", rep(".", 53)};

    test_reset();
    test_basic();
    test_all_ones();
    test_cost63_dec();
    test_hex_cost(h1, 8'h30, 8'h36);
    test_hex_cost(h63, 8'h33, 8'h66);
    test_stall();
    test_reset_mid();
    test_ignore_capture();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
